// File: rtl/mini_src_io_bank.sv
// Mini SRC I/O port bank: NIN buffered input channels (FIFO per channel) and
// NOUT handshaked output registers, shared by the CPU in/out instruction path.
module mini_src_io_bank #(
  parameter int WIDTH = 32,
  parameter int NIN   = 2,
  parameter int NOUT  = 2,
  parameter int DEPTH = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_rd,
  output logic [WIDTH-1:0]      cpu_rdata,
  input  logic [SEL_W-1:0]      out_sel,
  input  logic                  out_wr,
  input  logic [WIDTH-1:0]      cpu_wdata,
  input  logic [NIN*WIDTH-1:0]  ext_in_data,
  input  logic [NIN-1:0]        ext_in_valid,
  output logic [NIN-1:0]        ext_in_ready,
  output logic [NIN-1:0]        in_avail,
  output logic [NOUT*WIDTH-1:0] ext_out_data,
  output logic [NOUT-1:0]       ext_out_valid,
  input  logic [NOUT-1:0]       ext_out_ack,
  output logic [NOUT-1:0]       out_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [NIN*WIDTH-1:0] head_flat;
  logic [NIN*WIDTH-1:0] last_flat;

  for (genvar i = 0; i < NIN; i++) begin : g_in
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] last_q;
    logic             push;
    logic             pop;

    // Ready comes from the registered count only; a pop on an empty FIFO is dropped.
    assign push = ext_in_valid[i] && (cnt != CW'(DEPTH));
    assign pop  = in_rd && (in_sel == SEL_W'(i)) && (cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rptr   <= '0;
        wptr   <= '0;
        cnt    <= '0;
        last_q <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) begin
          rptr   <= rptr + 1'b1;
          last_q <= mem[rptr];
        end
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= ext_in_data[i*WIDTH +: WIDTH];
    end

    assign ext_in_ready[i]                = (cnt != CW'(DEPTH));
    assign in_avail[i]                    = (cnt != '0);
    assign head_flat[i*WIDTH +: WIDTH]    = mem[rptr];
    assign last_flat[i*WIDTH +: WIDTH]    = last_q;
  end

  // Unmapped channel numbers read as zero.
  always_comb begin
    cpu_rdata = '0;
    for (int i = 0; i < NIN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        cpu_rdata = in_avail[i] ? head_flat[i*WIDTH +: WIDTH]
                                : last_flat[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar j = 0; j < NOUT; j++) begin : g_out
    logic [WIDTH-1:0] data_q;
    logic             vld_q;
    logic             ovf_q;
    logic             wr;

    assign wr = out_wr && (out_sel == SEL_W'(j));

    // A write in the same cycle as an ack consumes the old word cleanly.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q <= '0;
        vld_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (wr) begin
        data_q <= cpu_wdata;
        vld_q  <= 1'b1;
        if (vld_q && !ext_out_ack[j]) ovf_q <= 1'b1;
      end else if (vld_q && ext_out_ack[j]) begin
        vld_q <= 1'b0;
      end
    end

    assign ext_out_data[j*WIDTH +: WIDTH] = data_q;
    assign ext_out_valid[j]               = vld_q;
    assign out_ovf[j]                     = ovf_q;
  end

endmodule

// File: tb/tb_mini_src_io_bank.sv
// Directed bench for mini_src_io_bank: default 2x2 instance plus a 3x3 instance
// for unmapped channel numbers.
module tb_mini_src_io_bank;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Default instance (NIN=2, NOUT=2)
  logic [1:0]  in_sel = '0, out_sel = '0;
  logic        in_rd = 1'b0, out_wr = 1'b0;
  logic [31:0] cpu_wdata = '0, cpu_rdata;
  logic [63:0] ext_in_data = '0, ext_out_data;
  logic [1:0]  ext_in_valid = '0, ext_in_ready, in_avail, ext_out_valid, out_ovf;
  logic [1:0]  ext_out_ack = '0;

  mini_src_io_bank dut (
    .clk(clk), .reset(reset), .in_sel(in_sel), .in_rd(in_rd), .cpu_rdata(cpu_rdata),
    .out_sel(out_sel), .out_wr(out_wr), .cpu_wdata(cpu_wdata),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .in_avail(in_avail), .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid),
    .ext_out_ack(ext_out_ack), .out_ovf(out_ovf));

  // Three-channel instance
  logic [1:0]  b_in_sel = '0, b_out_sel = '0;
  logic        b_in_rd = 1'b0, b_out_wr = 1'b0;
  logic [31:0] b_cpu_wdata = '0, b_cpu_rdata;
  logic [95:0] b_ext_in_data = '0, b_ext_out_data;
  logic [2:0]  b_ext_in_valid = '0, b_ext_in_ready, b_in_avail, b_ext_out_valid, b_out_ovf;
  logic [2:0]  b_ext_out_ack = '0;

  mini_src_io_bank #(.NIN(3), .NOUT(3)) dut_b (
    .clk(clk), .reset(reset), .in_sel(b_in_sel), .in_rd(b_in_rd), .cpu_rdata(b_cpu_rdata),
    .out_sel(b_out_sel), .out_wr(b_out_wr), .cpu_wdata(b_cpu_wdata),
    .ext_in_data(b_ext_in_data), .ext_in_valid(b_ext_in_valid), .ext_in_ready(b_ext_in_ready),
    .in_avail(b_in_avail), .ext_out_data(b_ext_out_data), .ext_out_valid(b_ext_out_valid),
    .ext_out_ack(b_ext_out_ack), .out_ovf(b_out_ovf));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    in_rd = 1'b0; out_wr = 1'b0; ext_in_valid = '0; ext_out_ack = '0;
  endtask

  typedef struct {
    logic [1:0]  sel;  logic rd;  logic [1:0] osel; logic owr; logic [31:0] wd;
    logic [1:0]  iv;   logic [31:0] d0; logic [31:0] d1; logic [1:0] ack;
    logic [31:0] e_rd; logic [1:0] e_rdy; logic [1:0] e_av; logic [1:0] e_ov;
    logic [1:0]  e_ovf; logic [63:0] e_od;
  } vec_t;

  vec_t tbl [20];

  initial begin
    // Row: inputs applied this cycle; expectations are outputs observed this cycle, before the edge.
    tbl[0]  = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b01,32'h11,32'h0,2'b00, 32'h0, 2'b11,2'b00,2'b00,2'b00,64'h0};
    tbl[1]  = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b01,32'h22,32'h0,2'b00, 32'h11,2'b11,2'b01,2'b00,2'b00,64'h0};
    tbl[2]  = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b01,32'h33,32'h0,2'b00, 32'h11,2'b11,2'b01,2'b00,2'b00,64'h0};
    tbl[3]  = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b01,32'h44,32'h0,2'b00, 32'h11,2'b11,2'b01,2'b00,2'b00,64'h0};
    tbl[4]  = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b01,32'h55,32'h0,2'b00, 32'h11,2'b10,2'b01,2'b00,2'b00,64'h0};
    tbl[5]  = '{2'd0,1'b1,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b00, 32'h11,2'b10,2'b01,2'b00,2'b00,64'h0};
    tbl[6]  = '{2'd0,1'b1,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b00, 32'h22,2'b11,2'b01,2'b00,2'b00,64'h0};
    tbl[7]  = '{2'd0,1'b1,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b00, 32'h33,2'b11,2'b01,2'b00,2'b00,64'h0};
    tbl[8]  = '{2'd0,1'b1,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b00, 32'h44,2'b11,2'b01,2'b00,2'b00,64'h0};
    tbl[9]  = '{2'd0,1'b1,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b00, 32'h44,2'b11,2'b00,2'b00,2'b00,64'h0};
    tbl[10] = '{2'd0,1'b1,2'd0,1'b0,32'h0,        2'b01,32'hA5,32'h0,2'b00, 32'h44,2'b11,2'b00,2'b00,2'b00,64'h0};
    tbl[11] = '{2'd0,1'b1,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b00, 32'hA5,2'b11,2'b01,2'b00,2'b00,64'h0};
    tbl[12] = '{2'd0,1'b0,2'd1,1'b1,32'hDEADBEEF, 2'b00,32'h0, 32'h0,2'b00, 32'hA5,2'b11,2'b00,2'b00,2'b00,64'h0};
    tbl[13] = '{2'd0,1'b0,2'd1,1'b1,32'h12345678, 2'b00,32'h0, 32'h0,2'b00, 32'hA5,2'b11,2'b00,2'b10,2'b00,{32'hDEADBEEF,32'h0}};
    tbl[14] = '{2'd0,1'b0,2'd0,1'b1,32'hCAFEF00D, 2'b00,32'h0, 32'h0,2'b00, 32'hA5,2'b11,2'b00,2'b10,2'b10,{32'h12345678,32'h0}};
    tbl[15] = '{2'd0,1'b0,2'd0,1'b1,32'h0BADC0DE, 2'b00,32'h0, 32'h0,2'b01, 32'hA5,2'b11,2'b00,2'b11,2'b10,{32'h12345678,32'hCAFEF00D}};
    tbl[16] = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b01, 32'hA5,2'b11,2'b00,2'b11,2'b10,{32'h12345678,32'h0BADC0DE}};
    tbl[17] = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b10, 32'hA5,2'b11,2'b00,2'b10,2'b10,{32'h12345678,32'h0BADC0DE}};
    tbl[18] = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b11, 32'hA5,2'b11,2'b00,2'b00,2'b10,{32'h12345678,32'h0BADC0DE}};
    tbl[19] = '{2'd0,1'b0,2'd0,1'b0,32'h0,        2'b00,32'h0, 32'h0,2'b00, 32'hA5,2'b11,2'b00,2'b00,2'b10,{32'h12345678,32'h0BADC0DE}};

    // Reset, then traffic, then an asynchronous reset in the middle of it
    repeat (2) step();
    @(negedge clk); reset = 1'b1;
    step();
    ext_in_valid = 2'b11; ext_in_data = {32'hBB, 32'hAA};
    out_sel = 2'd0; out_wr = 1'b1; cpu_wdata = 32'h1;
    step(); step();
    chk("pre_reset_ovf", out_ovf, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("rst_rdata_sel0", cpu_rdata, 32'h0);
    chk("rst_ready", ext_in_ready, 2'b11);
    chk("rst_avail", in_avail, 2'b00);
    chk("rst_out_valid", ext_out_valid, 2'b00);
    chk("rst_out_ovf", out_ovf, 2'b00);
    chk("rst_out_data", ext_out_data, 64'h0);
    step();
    in_sel = 2'd1; #1;
    chk("rst_rdata_sel1_held", cpu_rdata, 32'h0);
    chk("rst_avail_held", in_avail, 2'b00);
    idle_a(); in_sel = 2'd0;
    @(negedge clk); reset = 1'b1;
    step();
    chk("post_rst_avail", in_avail, 2'b00);
    chk("post_rst_rdata", cpu_rdata, 32'h0);

    // Fill/drain, empty push+pop, output handshake
    for (int r = 0; r < 20; r++) begin
      in_sel = tbl[r].sel; in_rd = tbl[r].rd; out_sel = tbl[r].osel; out_wr = tbl[r].owr;
      cpu_wdata = tbl[r].wd; ext_in_valid = tbl[r].iv; ext_in_data = {tbl[r].d1, tbl[r].d0};
      ext_out_ack = tbl[r].ack;
      #1;
      chk($sformatf("row%0d_rdata", r), cpu_rdata, tbl[r].e_rd);
      chk($sformatf("row%0d_ready", r), ext_in_ready, tbl[r].e_rdy);
      chk($sformatf("row%0d_avail", r), in_avail, tbl[r].e_av);
      chk($sformatf("row%0d_out_valid", r), ext_out_valid, tbl[r].e_ov);
      chk($sformatf("row%0d_out_ovf", r), out_ovf, tbl[r].e_ovf);
      chk($sformatf("row%0d_out_data", r), ext_out_data, tbl[r].e_od);
      step();
    end
    idle_a();

    // Ch1 steady push+pop at count 2 across several pointer wraps
    ext_in_valid = 2'b10; ext_in_data = {32'd1, 32'h0}; step();
    ext_in_data = {32'd2, 32'h0}; step();
    for (int k = 0; k < 10; k++) begin
      in_sel = 2'd1; in_rd = 1'b1; ext_in_valid = 2'b10; ext_in_data = {32'(k + 3), 32'h0};
      #1;
      chk($sformatf("wrap%0d_rdata", k), cpu_rdata, 32'(k + 1));
      chk($sformatf("wrap%0d_avail", k), in_avail, 2'b10);
      step();
    end
    idle_a(); #1;
    chk("wrap_ready", ext_in_ready, 2'b11);
    in_sel = 2'd0; #1;
    chk("wrap_ch0_untouched", cpu_rdata, 32'hA5);
    in_sel = 2'd1; in_rd = 1'b1; #1;
    chk("wrap_drain0", cpu_rdata, 32'd11);
    step(); #1;
    chk("wrap_drain1", cpu_rdata, 32'd12);
    step(); in_rd = 1'b0; #1;
    chk("wrap_empty_avail", in_avail, 2'b00);
    chk("wrap_empty_last", cpu_rdata, 32'd12);

    // Unmapped channels on the three-channel instance
    b_ext_in_valid = 3'b001; b_ext_in_data = {64'h0, 32'h77}; step();
    b_ext_in_valid = '0; b_in_sel = 2'd3; b_in_rd = 1'b1; #1;
    chk("oor_rdata", b_cpu_rdata, 32'h0);
    step(); b_in_rd = 1'b0; b_in_sel = 2'd0; #1;
    chk("oor_no_pop_rdata", b_cpu_rdata, 32'h77);
    chk("oor_no_pop_avail", b_in_avail, 3'b001);
    b_out_sel = 2'd3; b_out_wr = 1'b1; b_cpu_wdata = 32'hFFFF_FFFF; step();
    b_out_wr = 1'b0; #1;
    chk("oor_wr_valid", b_ext_out_valid, 3'b000);
    chk("oor_wr_data", b_ext_out_data, 96'h0);
    b_out_sel = 2'd2; b_out_wr = 1'b1; b_cpu_wdata = 32'h99; step();
    b_out_wr = 1'b0; #1;
    chk("ch2_wr_valid", b_ext_out_valid, 3'b100);
    chk("ch2_wr_data", b_ext_out_data, {32'h99, 64'h0});
    chk("ch2_wr_ovf", b_out_ovf, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mini_src_io_bank.md
# mini_src_io_bank

Parametrised I/O port bank for the Mini SRC processor. It generalises the single 32-bit INPORT/OUTPORT pair into NIN buffered input channels and NOUT handshaked output channels. The CPU side connects to the DataPath's `in`/`out` instruction path. The external side connects to peripherals through valid/ready on inputs and valid/ack on outputs.

## Interface
- WIDTH, 32: data width of every channel.
- NIN, 2: number of input channels (1..2**SEL_W).
- NOUT, 2: number of output channels (1..2**SEL_W).
- DEPTH, 4: per-input-channel FIFO depth; power of two, ≥2.
- SEL_W, 2: width of channel-select fields.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_sel  in  SEL_W  input channel addressed by CPU read.
- in_rd  in  1  CPU read strobe; pops selected FIFO.
- cpu_rdata  out  WIDTH  read data for in_sel (combinational).
- out_sel  in  SEL_W  output channel addressed by CPU write.
- out_wr  in  1  CPU write strobe.
- cpu_wdata  in  WIDTH  write data.
- ext_in_data  in  NIN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- ext_in_valid  in  NIN  peripheral offers a word.
- ext_in_ready  out  NIN  FIFO not full.
- in_avail  out  NIN  FIFO not empty.
- ext_out_data  out  NOUT*WIDTH  output registers, packed as inputs.
- ext_out_valid  out  NOUT  word pending for peripheral.
- ext_out_ack  in  NOUT  peripheral consumed pending word.
- out_ovf  out  NOUT  sticky: pending word overwritten before ack.

## Operation
- Input channel i:
  - Circular FIFO with read/write pointers and a count of log2(DEPTH)+1 bits.
  - Push when ext_in_valid[i] && ext_in_ready[i].
  - ext_in_ready[i] = (count != DEPTH).
  - Pop when in_rd && in_sel==i && count!=0.
  - Each channel holds a last-read register `last[i]`. It is loaded with the head word on every successful pop.
- cpu_rdata:
  - in_sel<NIN and FIFO non-empty: FIFO head.
  - in_sel<NIN and FIFO empty: last[in_sel].
  - in_sel≥NIN: 0.
- Empty read: no pop; pointers unchanged.
- Full FIFO: ready low, so no push. A pop in the same cycle still occurs, and ready rises the next cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO: count is unchanged; both pointers advance.
- Simultaneous push and pop on an empty FIFO: push only; the pop is ignored and last is unchanged.
- Pointers wrap modulo DEPTH.
- Output channel j, write (out_wr && out_sel==j, j<NOUT):
  - Load the register with cpu_wdata and set ext_out_valid[j].
- Output channel j, ack:
  - ext_out_ack[j] && ext_out_valid[j] clears valid. An ack while valid is low is ignored.
- Write while valid=1 without ack in the same cycle:
  - Data is overwritten, valid stays 1, and out_ovf[j] is set.
- Write and ack in the same cycle:
  - The old word is treated as consumed. New data is loaded, valid stays 1, and out_ovf is not set.
- out_ovf clears only on reset.
- out_sel≥NOUT: write ignored.
- Reset (async assert, any time including mid-transfer):
  - All FIFOs empty; pointers and counts 0.
  - ext_in_ready = all 1s; in_avail = 0.
  - last = 0; ext_out_data = 0; ext_out_valid = 0; out_ovf = 0.
  - cpu_rdata = 0 for any in_sel.
- Reset release is synchronous to the next clk edge; there are no in-flight words to recover.

## Timing
- All state updates on rising clk; reset overrides asynchronously.
- Pushed word: in_avail and cpu_rdata visible 1 cycle after the push edge.
- Pop: next head (or last) visible on cpu_rdata 1 cycle after the in_rd edge. The CPU samples cpu_rdata in the same cycle it asserts in_rd.
- Output write: ext_out_data/ext_out_valid visible the cycle after the out_wr edge.
- Ack clears valid the cycle after the ack edge.
- Throughput:
  - One push per channel per cycle (all channels concurrently).
  - One CPU read and one CPU write per cycle.
- ext_in_ready depends only on registered count; no combinational path from ext_in_valid.

## Test plan
- Reset: with defaults, hold reset=0 mid-traffic → all outputs 0 except ext_in_ready=2'b11. After release, FIFOs are empty, and in_sel=0 read gives cpu_rdata=0.
- Fill/drain ch0:
  - Push 0x11,0x22,0x33,0x44 → ready[0]=0, in_avail[0]=1.
  - A fifth valid (0x55) is not accepted.
  - Four reads return 0x11..0x44.
  - A fifth read returns 0x44 (last) with no pointer change.
- Wrap and concurrency: over 10 cycles, push every cycle on ch1 while reading ch1 every cycle from count=2 → count stays 2. Data order is preserved across pointer wrap; ch0 is unaffected.
- Empty push+pop: ch0 empty; push 0xA5 and read the same cycle → next cycle count=1, head=0xA5, last is unchanged.
- Output handshake:
  - Write 0xDEADBEEF to out1 → next cycle valid[1]=1.
  - Write 0x12345678 before ack → data updated, out_ovf[1]=1.
  - Write plus ack in the same cycle on out0 → valid stays 1, out_ovf[0]=0.
  - Ack alone → valid clears.
- Out-of-range: with NIN=3, NOUT=3, in_sel=3 read → cpu_rdata=0, no pop. out_sel=3 write → no register changes.
